// File: rtl/mips32_fetch_queue_if.sv
// rtl/mips32_fetch_queue_if.sv - imem, redirect and decode signal bundle of the fetch queue
interface mips32_fetch_queue_if #(
   parameter int ADDR_W = 10
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              id_valid;
   logic              id_ready;
   logic [31:0]       id_ir;
   logic [31:0]       id_npc;
   logic              fetch_halted;

   modport master (
      output imem_req, imem_addr, id_valid, id_ir, id_npc, fetch_halted,
      input  imem_rdata, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_ir, id_npc, fetch_halted,
      output imem_rdata, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/mips32_fetch_queue.sv
// rtl/mips32_fetch_queue.sv - MIPS32 fetch front end: PC, imem requests, prefetch FIFO to decode
module mips32_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic                clk,
   input  logic                rst_n,
   mips32_fetch_queue_if.master fq_if
);
   localparam int             PTR_W   = $clog2(DEPTH);
   localparam int             CNT_W   = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);
   localparam logic [5:0]     HLT_OP  = 6'b111111;

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      req_pc_q, req_pc_d;
   logic             pending_q, pending_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   logic [31:0]      ir_mem  [DEPTH];
   logic [31:0]      npc_mem [DEPTH];

   logic             req;
   logic             push;
   logic             pop;
   logic             valid;
   logic [CNT_W:0]   credit;

   // Credit counts the in-flight response but not a same-cycle pop, so a
   // returning word always finds a free slot.
   always_comb begin
      credit = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
      req    = rst_n & ~fq_if.redirect_valid & ~halt_q & (credit < DEPTH_C);
      push   = pending_q & ~fq_if.redirect_valid;
      valid  = (count_q != '0);
      pop    = valid & fq_if.id_ready;
   end

   always_comb begin
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      pending_d = req;
      halt_d    = halt_q;
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (fq_if.redirect_valid) begin
         pc_d     = fq_if.redirect_pc;
         halt_d   = 1'b0;
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (req) begin
            pc_d     = pc_q + 32'd1;
            req_pc_d = pc_q;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (fq_if.imem_rdata[31:26] == HLT_OP) halt_d = 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         req_pc_q  <= RESET_PC;
         pending_q <= 1'b0;
         halt_q    <= 1'b0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         pending_q <= pending_d;
         halt_q    <= halt_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         ir_mem[wr_ptr_q]  <= fq_if.imem_rdata;
         npc_mem[wr_ptr_q] <= req_pc_q + 32'd1;
      end
   end

   assign fq_if.imem_req     = req;
   assign fq_if.imem_addr    = pc_q[ADDR_W-1:0];
   assign fq_if.id_valid     = valid;
   assign fq_if.id_ir        = valid ? ir_mem[rd_ptr_q]  : 32'd0;
   assign fq_if.id_npc       = valid ? npc_mem[rd_ptr_q] : 32'd0;
   assign fq_if.fetch_halted = halt_q;
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb/tb_mips32_fetch_queue.sv - directed and model-checked bench for mips32_fetch_queue
module tb_mips32_fetch_queue;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mips32_fetch_queue_if #(.ADDR_W(ADDR_W)) fq_if ();

   mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'd0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fq_if (fq_if)
   );

   logic [31:0] mem [1024];
   int total = 0;
   int bad   = 0;

   always @(posedge clk) if (fq_if.imem_req) fq_if.imem_rdata <= mem[fq_if.imem_addr];

   task automatic init_mem();
      for (int k = 0; k < 1024; k++) mem[k] = 32'h28000000 + k;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fq_if.redirect_valid = 1'b0;
      fq_if.redirect_pc = 32'd0;
      fq_if.id_ready = 1'b1;
      cyc(); cyc();
      #1;
      total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", fq_if.imem_req); end
      total++; if (fq_if.id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", fq_if.id_valid); end
      total++; if (fq_if.id_ir !== 32'd0) begin bad++; $display("FAIL rst_ir got=%h exp=0", fq_if.id_ir); end
      total++; if (fq_if.id_npc !== 32'd0) begin bad++; $display("FAIL rst_npc got=%h exp=0", fq_if.id_npc); end
      total++; if (fq_if.fetch_halted !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b exp=0", fq_if.fetch_halted); end
   endtask

   // Release from reset; leaves word 8 at the head with word 9 in flight.
   task automatic test_stream();
      rst_n = 1'b1;
      fq_if.id_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (c == 0) begin
            total++; if (fq_if.imem_req !== 1'b1) begin bad++; $display("FAIL stream_req0 got=%b exp=1", fq_if.imem_req); end
            total++; if (fq_if.imem_addr !== 10'd0) begin bad++; $display("FAIL stream_addr0 got=%0d exp=0", fq_if.imem_addr); end
         end
         if (c < 2) begin
            total++; if (fq_if.id_valid !== 1'b0) begin bad++; $display("FAIL stream_valid_c%0d got=%b exp=0", c, fq_if.id_valid); end
         end else begin
            total++; if (fq_if.id_valid !== 1'b1) begin bad++; $display("FAIL stream_valid_c%0d got=%b exp=1", c, fq_if.id_valid); end
            total++; if (fq_if.id_ir !== 32'h28000000 + 32'(c - 2)) begin bad++; $display("FAIL stream_ir_c%0d got=%h exp=%h", c, fq_if.id_ir, 32'h28000000 + 32'(c - 2)); end
            total++; if (fq_if.id_npc !== 32'(c - 1)) begin bad++; $display("FAIL stream_npc_c%0d got=%0d exp=%0d", c, fq_if.id_npc, c - 1); end
         end
         cyc();
      end
   endtask

   task automatic test_stall();
      int reqs;
      reqs = 0;
      fq_if.id_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (fq_if.imem_req === 1'b1) reqs++;
         cyc();
      end
      #1;
      total++; if (reqs !== 2) begin bad++; $display("FAIL stall_reqs got=%0d exp=2", reqs); end
      total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL stall_full_req got=%b exp=0", fq_if.imem_req); end
      fq_if.id_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         total++; if (fq_if.id_valid !== 1'b1) begin bad++; $display("FAIL resume_valid_%0d got=%b exp=1", i, fq_if.id_valid); end
         total++; if (fq_if.id_ir !== 32'h28000000 + 32'(8 + i)) begin bad++; $display("FAIL resume_ir_%0d got=%h exp=%h", i, fq_if.id_ir, 32'h28000000 + 32'(8 + i)); end
         total++; if (fq_if.id_npc !== 32'(9 + i)) begin bad++; $display("FAIL resume_npc_%0d got=%0d exp=%0d", i, fq_if.id_npc, 9 + i); end
         cyc();
      end
   endtask

   task automatic test_redirect();
      rst_n = 1'b0; fq_if.id_ready = 1'b1; fq_if.redirect_valid = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int c = 0; c < 7; c++) begin
         fq_if.id_ready = (c < 5);
         #1;
         if (c == 6) begin
            total++; if (fq_if.imem_req !== 1'b1 || fq_if.imem_addr !== 10'd6) begin bad++; $display("FAIL redir_req6 got=%b/%0d exp=1/6", fq_if.imem_req, fq_if.imem_addr); end
         end
         cyc();
      end
      fq_if.redirect_valid = 1'b1; fq_if.redirect_pc = 32'd8;
      #1;
      total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL redir_r_req got=%b exp=0", fq_if.imem_req); end
      total++; if (fq_if.id_valid !== 1'b1 || fq_if.id_ir !== 32'h28000003) begin bad++; $display("FAIL redir_r_head got=%b/%h exp=1/28000003", fq_if.id_valid, fq_if.id_ir); end
      cyc();
      fq_if.redirect_valid = 1'b0; fq_if.id_ready = 1'b1;
      #1;
      total++; if (fq_if.imem_req !== 1'b1 || fq_if.imem_addr !== 10'd8) begin bad++; $display("FAIL redir_r1_req got=%b/%0d exp=1/8", fq_if.imem_req, fq_if.imem_addr); end
      total++; if (fq_if.id_valid !== 1'b0) begin bad++; $display("FAIL redir_r1_valid got=%b exp=0", fq_if.id_valid); end
      cyc(); #1;
      total++; if (fq_if.id_valid !== 1'b0) begin bad++; $display("FAIL redir_r2_valid got=%b exp=0", fq_if.id_valid); end
      cyc(); #1;
      total++; if (fq_if.id_valid !== 1'b1 || fq_if.id_ir !== 32'h28000008 || fq_if.id_npc !== 32'd9) begin bad++; $display("FAIL redir_r3 got=%b/%h/%0d exp=1/28000008/9", fq_if.id_valid, fq_if.id_ir, fq_if.id_npc); end
      cyc(); #1;
      total++; if (fq_if.id_ir !== 32'h28000009 || fq_if.id_npc !== 32'd10) begin bad++; $display("FAIL redir_r4 got=%h/%0d exp=28000009/10", fq_if.id_ir, fq_if.id_npc); end
      cyc();
   endtask

   task automatic test_halt();
      mem[3] = 32'hfc000000;
      rst_n = 1'b0; fq_if.id_ready = 1'b1; fq_if.redirect_valid = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (c >= 2 && c <= 5) begin
            total++; if (fq_if.id_ir !== mem[c - 2]) begin bad++; $display("FAIL halt_ir_c%0d got=%h exp=%h", c, fq_if.id_ir, mem[c - 2]); end
         end
         if (c == 4) begin
            total++; if (fq_if.fetch_halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", fq_if.fetch_halted); end
         end
         if (c >= 5) begin
            total++; if (fq_if.fetch_halted !== 1'b1) begin bad++; $display("FAIL halt_flag_c%0d got=%b exp=1", c, fq_if.fetch_halted); end
            total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL halt_req_c%0d got=%b exp=0", c, fq_if.imem_req); end
         end
         cyc();
      end
      mem[3] = 32'h28000003;
      fq_if.redirect_valid = 1'b1; fq_if.redirect_pc = 32'd0;
      #1;
      total++; if (fq_if.imem_req !== 1'b0 || fq_if.fetch_halted !== 1'b1) begin bad++; $display("FAIL halt_redir got=%b/%b exp=0/1", fq_if.imem_req, fq_if.fetch_halted); end
      cyc();
      fq_if.redirect_valid = 1'b0;
      #1;
      total++; if (fq_if.fetch_halted !== 1'b0) begin bad++; $display("FAIL halt_clear got=%b exp=0", fq_if.fetch_halted); end
      total++; if (fq_if.imem_req !== 1'b1 || fq_if.imem_addr !== 10'd0) begin bad++; $display("FAIL halt_resume got=%b/%0d exp=1/0", fq_if.imem_req, fq_if.imem_addr); end
      cyc(); cyc(); #1;
      total++; if (fq_if.id_valid !== 1'b1 || fq_if.id_ir !== 32'h28000000) begin bad++; $display("FAIL halt_resume_ir got=%b/%h exp=1/28000000", fq_if.id_valid, fq_if.id_ir); end
      cyc();
   endtask

   task automatic test_reset_midstream();
      fq_if.id_ready = 1'b0;
      repeat (8) cyc();
      #1;
      total++; if (fq_if.id_valid !== 1'b1 || fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL mid_full got=%b/%b exp=1/0", fq_if.id_valid, fq_if.imem_req); end
      rst_n = 1'b0;
      #1;
      total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%b exp=0", fq_if.imem_req); end
      cyc();
      rst_n = 1'b1; fq_if.id_ready = 1'b1;
      #1;
      total++; if (fq_if.id_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", fq_if.id_valid); end
      total++; if (fq_if.imem_req !== 1'b1 || fq_if.imem_addr !== 10'd0) begin bad++; $display("FAIL mid_req got=%b/%0d exp=1/0", fq_if.imem_req, fq_if.imem_addr); end
      cyc(); #1;
      total++; if (fq_if.id_valid !== 1'b0) begin bad++; $display("FAIL mid_valid1 got=%b exp=0", fq_if.id_valid); end
      cyc(); #1;
      total++; if (fq_if.id_valid !== 1'b1 || fq_if.id_ir !== 32'h28000000 || fq_if.id_npc !== 32'd1) begin bad++; $display("FAIL mid_first got=%b/%h/%0d exp=1/28000000/1", fq_if.id_valid, fq_if.id_ir, fq_if.id_npc); end
      cyc();
   endtask

   task automatic test_random();
      int occ, pend;
      logic [31:0] mpc, exp_addr;
      logic redir, exp_req, pop;
      rst_n = 1'b0; fq_if.redirect_valid = 1'b0; fq_if.id_ready = 1'b0;
      cyc();
      rst_n = 1'b1;
      occ = 0; pend = 0; mpc = 32'd0; exp_addr = 32'd0;
      for (int c = 0; c < 400; c++) begin
         fq_if.id_ready = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 9) == 0);
         fq_if.redirect_valid = redir;
         fq_if.redirect_pc = 32'($urandom_range(0, 900));
         #1;
         exp_req = !redir && (occ + pend < DEPTH);
         total++; if (fq_if.imem_req !== exp_req) begin bad++; $display("FAIL rnd_req_c%0d got=%b exp=%b", c, fq_if.imem_req, exp_req); end
         if (exp_req) begin
            total++; if (fq_if.imem_addr !== mpc[9:0]) begin bad++; $display("FAIL rnd_addr_c%0d got=%0d exp=%0d", c, fq_if.imem_addr, mpc[9:0]); end
         end
         total++; if (fq_if.id_valid !== (occ != 0)) begin bad++; $display("FAIL rnd_valid_c%0d got=%b exp=%b", c, fq_if.id_valid, occ != 0); end
         pop = (occ != 0) && fq_if.id_ready;
         if (pop) begin
            total++; if (fq_if.id_npc !== exp_addr + 32'd1 || fq_if.id_ir !== mem[exp_addr[9:0]]) begin bad++; $display("FAIL rnd_pop_c%0d got=%h/%0d exp=%h/%0d", c, fq_if.id_ir, fq_if.id_npc, mem[exp_addr[9:0]], exp_addr + 32'd1); end
            exp_addr = exp_addr + 32'd1;
         end
         if (redir) begin
            occ = 0; pend = 0;
            mpc = fq_if.redirect_pc; exp_addr = fq_if.redirect_pc;
         end else begin
            occ = occ + pend - (pop ? 1 : 0);
            if (exp_req) mpc = mpc + 32'd1;
            pend = exp_req ? 1 : 0;
         end
         cyc();
      end
      fq_if.redirect_valid = 1'b0;
   endtask

   initial begin
      init_mem();
      fq_if.redirect_valid = 1'b0;
      fq_if.redirect_pc = 32'd0;
      fq_if.id_ready = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_halt();
      test_reset_midstream();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
